// File: rtl/ppu_pkg.sv
// Shared types, timing constants and address decode for the PPU table-write scheduler.
package ppu_pkg;

    localparam int HTOTAL  = 1600;
    localparam int HACTIVE = 1280;
    localparam int VACTIVE = 480;
    localparam int VTOTAL  = 525;

    typedef enum logic [1:0] {TGT_ATTR, TGT_COLOR, TGT_SPRITE} ppu_tgt_t;

    typedef enum logic {ST_IDLE, ST_DRAIN} ppu_state_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } ppu_entry_t;

    function automatic ppu_tgt_t ppu_target(input logic [15:0] address);
        case (address[9:8])
            2'b00:   ppu_target = TGT_ATTR;
            2'b01:   ppu_target = TGT_COLOR;
            default: ppu_target = TGT_SPRITE;
        endcase
    endfunction

    // One-hot table strobe: [0] attr, [1] colour, [2] sprite.
    function automatic logic [2:0] ppu_decode(input logic [15:0] address);
        case (ppu_target(address))
            TGT_ATTR:  ppu_decode = 3'b001;
            TGT_COLOR: ppu_decode = 3'b010;
            default:   ppu_decode = 3'b100;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data; a full FIFO refuses pushes even when popping.
module sync_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
                dout   <= mem[rd_ptr];
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ppu_write_scheduler.sv
// Queues host table writes and commits one per cycle to the PPU tables.
// Define PPU_VBLANK_COMMIT_EN to restrict commits to the vertical blank window.
module ppu_write_scheduler #(
    parameter int FIFO_DEPTH = 16,
    parameter int VACTIVE    = 480,
    parameter int VTOTAL     = 525
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          chipselect,
    input  logic                          write,
    input  logic [15:0]                   address,
    input  logic [31:0]                   writedata,
    output logic                          waitrequest,
    input  logic [10:0]                   hcount,
    input  logic [9:0]                    vcount,
    output logic [2:0]                    mem_write,
    output logic [15:0]                   w_addr,
    output logic [31:0]                   w_data,
    output logic [$clog2(FIFO_DEPTH):0]   pending,
    output logic                          frame_commit
);

    import ppu_pkg::*;

    ppu_state_t state;
    ppu_state_t state_next;
    ppu_entry_t push_entry;
    ppu_entry_t head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
    logic       pop_q;
    logic       open_evt;
    logic       close_evt;

    assign push_entry = '{addr: address, data: writedata};

    sync_fifo #(
        .WIDTH ($bits(ppu_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (chipselect && write),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (pending)
    );

    assign waitrequest = fifo_full;

`ifdef PPU_VBLANK_COMMIT_EN
    assign open_evt  = (vcount == 10'(VACTIVE))  && (hcount == 11'd0);
    assign close_evt = (vcount == 10'(VTOTAL-1)) && (hcount == 11'(HTOTAL-1));
`else
    logic [10:0] unused_win;
    assign unused_win = hcount ^ {1'b0, vcount} ^ 11'(VACTIVE) ^ 11'(VTOTAL);
    // Window permanently open: any queued entry starts a drain immediately.
    assign open_evt  = !fifo_empty;
    assign close_evt = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (open_evt) state_next = ST_DRAIN;
            ST_DRAIN: if (close_evt || fifo_empty) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // The opening cycle already pops, so the first commit is not delayed by the state change.
    always_comb begin
        pop = 1'b0;
        case (state)
            ST_IDLE:  pop = !fifo_empty && open_evt;
            ST_DRAIN: pop = !fifo_empty && !close_evt;
            default:  pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pop_q <= 1'b0;
        end else begin
            pop_q <= pop;
        end
    end

    // Registered FIFO read data holds the last entry, so address/data persist when idle.
    assign mem_write = pop_q ? ppu_decode(head.addr) : 3'b000;
    assign w_addr    = head.addr;
    assign w_data    = head.data;

`ifdef PPU_VBLANK_COMMIT_EN
    logic frame_commit_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_commit_q <= 1'b0;
        end else begin
            frame_commit_q <= (state == ST_DRAIN) && fifo_empty;
        end
    end
    assign frame_commit = frame_commit_q;
`else
    assign frame_commit = 1'b0;
`endif

endmodule
